// File: rtl/pipe_bshift_pkg.sv
// pipe_bshift shared definitions: shift mode encoding.
// Used by the interface, the stage and the top level.
package pipe_bshift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SLL = 2'b00;
  localparam mode_t MODE_SRL = 2'b01;
  localparam mode_t MODE_SRA = 2'b10;
  localparam mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/pipe_bshift_if.sv
// pipe_bshift stream bundle: operand side and result side
// of the valid/ready handshake.
interface pipe_bshift_if #(
  parameter int WIDTH = 8
);
  import pipe_bshift_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

endinterface

// File: rtl/pipe_bshift_stage.sv
// One registered barrel-shifter stage, shift by 2**STAGE.
// Rotate wrap is built only when PIPE_BSHIFT_ROTATE_EN is defined.
module pipe_bshift_stage
  import pipe_bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv,
  input  logic                       valid,
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(WIDTH)-1:0]   amt,
  input  mode_t                      mode,
  input  logic                       sign,
  output logic                       valid_q,
  output logic [WIDTH-1:0]           data_q,
  output logic [$clog2(WIDTH)-1:0]   amt_q,
  output mode_t                      mode_q,
  output logic                       sign_q
);

  localparam int SH = 1 << STAGE;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data;
    if (amt[STAGE]) begin
      unique case (mode)
        MODE_SLL: shifted = data << SH;
        MODE_SRA: shifted = {{SH{sign}}, data[WIDTH-1:SH]};
`ifdef PIPE_BSHIFT_ROTATE_EN
        MODE_SRL: shifted = data >> SH;
        MODE_ROR: shifted = {data[SH-1:0], data[WIDTH-1:SH]};
`else
        MODE_SRL,
        MODE_ROR: shifted = data >> SH;
`endif
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= MODE_SLL;
      sign_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= valid;
      data_q  <= shifted;
      amt_q   <= amt;
      mode_q  <= mode;
      sign_q  <= sign;
    end
  end

endmodule

// File: rtl/pipe_bshift.sv
// Pipelined barrel shifter, one registered stage per amount bit.
// Define PIPE_BSHIFT_ROTATE_EN to make mode 11 rotate right.
module pipe_bshift
  import pipe_bshift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_bshift_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             adv;
  logic             valid [SHW+1];
  logic [WIDTH-1:0] data  [SHW+1];
  logic [SHW-1:0]   amt   [SHW+1];
  mode_t            mode  [SHW+1];
  logic             sign  [SHW+1];

  assign valid[0] = bus.in_valid;
  assign data[0]  = bus.in_data;
  assign amt[0]   = bus.in_amt;
  assign mode[0]  = bus.in_mode;
  assign sign[0]  = bus.in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    pipe_bshift_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .valid   (valid[k]),
      .data    (data[k]),
      .amt     (amt[k]),
      .mode    (mode[k]),
      .sign    (sign[k]),
      .valid_q (valid[k+1]),
      .data_q  (data[k+1]),
      .amt_q   (amt[k+1]),
      .mode_q  (mode[k+1]),
      .sign_q  (sign[k+1])
    );
  end

  // whole pipe moves together; bubbles never block
  assign adv           = bus.out_ready | ~valid[SHW];
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid[SHW];
  assign bus.out_data  = data[SHW];
  assign bus.out_zero  = ~|data[SHW];

endmodule

// File: tb/tb_pipe_bshift.sv
// Bench for pipe_bshift: directed cases on an 8-bit instance,
// random traffic on 8- and 32-bit instances vs a reference model.
module tb_pipe_bshift;
  import pipe_bshift_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_bshift_if #(.WIDTH(8))  b8 ();
  pipe_bshift_if #(.WIDTH(32)) b32 ();

  pipe_bshift #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  pipe_bshift #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;
  exp_t q8[$];
  exp_t q32[$];
  logic [7:0] got8[$];
  logic z8[$];
  int ocyc8[$];
  int got32_n = 0;

  function automatic logic [31:0] model(
    input int w, input logic [31:0] d,
    input int a, input logic [1:0] m);
    logic [63:0] msk, x, r;
    msk = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & msk;
    case (m)
      MODE_SLL: r = (x << a) & msk;
      MODE_SRL: r = x >> a;
      MODE_SRA: begin
        r = x >> a;
        if (x[w-1]) r = r | (msk & ~(msk >> a));
      end
      default: begin
`ifdef PIPE_BSHIFT_ROTATE_EN
        r = ((x >> a) | (x << (w - a))) & msk;
`else
        r = x >> a;
`endif
      end
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(
    input logic v8, input logic [7:0] d8,
    input logic [2:0] a8, input logic [1:0] m8,
    input logic r8,
    input logic v32, input logic [31:0] d32,
    input logic [4:0] a32, input logic [1:0] m32,
    input logic r32);
    exp_t e;
    b8.in_valid   = v8;
    b8.in_data    = d8;
    b8.in_amt     = a8;
    b8.in_mode    = m8;
    b8.out_ready  = r8;
    b32.in_valid  = v32;
    b32.in_data   = d32;
    b32.in_amt    = a32;
    b32.in_mode   = m32;
    b32.out_ready = r32;
    #1;
    if (b8.out_valid) begin
      check("stale8", 32'(q8.size() != 0), 32'd1);
      if (b8.out_ready && q8.size() != 0) begin
        e = q8.pop_front();
        check("data8", 32'(b8.out_data), e.d);
        check("zero8", 32'(b8.out_zero), 32'(e.d == 0));
        if (lat_chk) check("lat8", 32'(cyc - e.c), 32'd3);
        got8.push_back(b8.out_data);
        z8.push_back(b8.out_zero);
        ocyc8.push_back(cyc);
      end
    end
    if (b32.out_valid) begin
      check("stale32", 32'(q32.size() != 0), 32'd1);
      if (b32.out_ready && q32.size() != 0) begin
        e = q32.pop_front();
        check("data32", b32.out_data, e.d);
        check("zero32", 32'(b32.out_zero), 32'(e.d == 0));
        got32_n++;
      end
    end
    if (b8.in_valid && b8.in_ready)
      q8.push_back('{model(8, 32'(b8.in_data),
                           int'(b8.in_amt), b8.in_mode), cyc});
    if (b32.in_valid && b32.in_ready)
      q32.push_back('{model(32, b32.in_data,
                            int'(b32.in_amt), b32.in_mode), cyc});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 3'd0, MODE_SLL, 1'b1,
         1'b0, 32'd0, 5'd0, MODE_SLL, 1'b1);
  endtask

  task automatic op8(input logic [7:0] d, input logic [2:0] a,
                     input logic [1:0] m, input logic [7:0] want,
                     input string tag);
    int n;
    n = got8.size();
    lat_chk = 1'b1;
    step(1'b1, d, a, m, 1'b1,
         1'b0, 32'd0, 5'd0, MODE_SLL, 1'b1);
    repeat (4) idle();
    check({tag, "_cnt"}, 32'(got8.size() - n), 32'd1);
    if (got8.size() > n) begin
      check(tag, 32'(got8[n]), 32'(want));
      check({tag, "_z"}, 32'(z8[n]), 32'(want == 8'd0));
    end
  endtask

  logic [7:0] b2b [8] = '{8'h81, 8'h40, 8'h20, 8'h10,
                          8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] frozen;
  logic [7:0] ror_want;
  int n0;

  initial begin
    b8.in_valid = 1'b0;   b8.in_data = '0;
    b8.in_amt = '0;       b8.in_mode = MODE_SLL;
    b8.out_ready = 1'b1;
    b32.in_valid = 1'b0;  b32.in_data = '0;
    b32.in_amt = '0;      b32.in_mode = MODE_SLL;
    b32.out_ready = 1'b1;
`ifdef PIPE_BSHIFT_ROTATE_EN
    ror_want = 8'b01011011;
`else
    ror_want = 8'b00011011;
`endif
    #12;
    check("rst_valid8", 32'(b8.out_valid), 32'd0);
    check("rst_data8", 32'(b8.out_data), 32'd0);
    check("rst_zero8", 32'(b8.out_zero), 32'd1);
    check("rst_ready8", 32'(b8.in_ready), 32'd1);
    check("rst_valid32", 32'(b32.out_valid), 32'd0);
    check("rst_zero32", 32'(b32.out_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'b11011010, 3'd7, MODE_SLL, 8'b00000000, "sll7");
    op8(8'b11011010, 3'd7, MODE_SRL, 8'b00000001, "srl7");
    op8(8'b11011010, 3'd3, MODE_SRA, 8'b11111011, "sra3");
    op8(8'b11011010, 3'd3, MODE_ROR, ror_want, "ror3");
    op8(8'b01011010, 3'd0, MODE_SRA, 8'b01011010, "sra0");

    n0 = got8.size();
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'h81, 3'(i), MODE_SRL, 1'b1,
           1'b0, 32'd0, 5'd0, MODE_SLL, 1'b1);
    repeat (4) idle();
    check("b2b_cnt", 32'(got8.size() - n0), 32'd8);
    if (got8.size() >= n0 + 8) begin
      for (int i = 0; i < 8; i++)
        check("b2b_val", 32'(got8[n0+i]), 32'(b2b[i]));
      check("b2b_span", 32'(ocyc8[n0+7] - ocyc8[n0]), 32'd7);
    end

    lat_chk = 1'b0;
    n0 = got8.size();
    repeat (3)
      step(1'b1, 8'($urandom), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'b0,
           1'b0, 32'd0, 5'd0, MODE_SLL, 1'b1);
    check("bp_full", 32'(b8.out_valid), 32'd1);
    frozen = b8.out_data;
    repeat (5) begin
      step(1'b1, 8'($urandom), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'b0,
           1'b0, 32'd0, 5'd0, MODE_SLL, 1'b1);
      check("bp_ready", 32'(b8.in_ready), 32'd0);
      check("bp_data", 32'(b8.out_data), 32'(frozen));
      check("bp_valid", 32'(b8.out_valid), 32'd1);
    end
    repeat (6) idle();
    check("bp_cnt", 32'(got8.size() - n0), 32'd3);
    check("bp_empty", 32'(q8.size()), 32'd0);

    repeat (3)
      step(1'b1, 8'hA5, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'b1,
           1'b0, 32'd0, 5'd0, MODE_SLL, 1'b1);
    check("pre_rst_valid", 32'(b8.out_valid), 32'd1);
    n0 = got8.size();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(b8.out_valid), 32'd0);
    check("mid_rst_data", 32'(b8.out_data), 32'd0);
    check("mid_rst_ready", 32'(b8.in_ready), 32'd1);
    q8.delete();
    q32.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) idle();
    check("rst_no_stale", 32'(got8.size() - n0), 32'd0);
    op8(8'b11011010, 3'd3, MODE_SRA, 8'b11111011, "post_rst");

    lat_chk = 1'b0;
    repeat (1000)
      step($urandom_range(0, 3) != 0, 8'($urandom),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom,
           5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0);
    repeat (10) idle();
    check("rand_empty8", 32'(q8.size()), 32'd0);
    check("rand_empty32", 32'(q32.size()), 32'd0);
    check("rand_seen32", 32'(got32_n > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
